// File: rtl/connect4_pkg.sv
// Shared types and constants for the connect4 match controller.
package connect4_pkg;

    typedef enum logic [1:0] {
        WAIT_REQ = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RE  = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam int COL_W  = 3;
    localparam int MOVE_W = 6;

    // A 7x6 board holds at most 42 discs.
    localparam logic [MOVE_W-1:0] MAX_MOVES = 6'd42;

endpackage

// File: rtl/connect4_match_ctrl_if.sv
// Handshake buses between players, match controller and connect4 engine.
interface connect4_match_ctrl_if;
    import connect4_pkg::*;

    logic             p0_req_valid;
    logic             p0_req_ready;
    logic [COL_W-1:0] p0_req_col;
    logic             p1_req_valid;
    logic             p1_req_ready;
    logic [COL_W-1:0] p1_req_col;

    logic             eng_op_valid;
    logic             eng_op_ready;
    logic             eng_op_player_id;
    logic [COL_W-1:0] eng_op_col_id;

    logic             eng_re_valid;
    logic             eng_re_ready;
    logic             eng_re_err;
    logic             eng_re_is_finished;
    logic             eng_re_winner;
    logic             eng_re_tie;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_player;
    logic             rsp_err;
    logic             rsp_finished;
    logic             rsp_winner;
    logic             rsp_tie;

    // master is the match controller, slave is the surrounding players/engine
    modport master (
        input  p0_req_valid, p0_req_col, p1_req_valid, p1_req_col,
        output p0_req_ready, p1_req_ready,
        output eng_op_valid, eng_op_player_id, eng_op_col_id,
        input  eng_op_ready,
        input  eng_re_valid, eng_re_err, eng_re_is_finished, eng_re_winner, eng_re_tie,
        output eng_re_ready,
        output rsp_valid, rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie,
        input  rsp_ready
    );

    modport slave (
        output p0_req_valid, p0_req_col, p1_req_valid, p1_req_col,
        input  p0_req_ready, p1_req_ready,
        input  eng_op_valid, eng_op_player_id, eng_op_col_id,
        output eng_op_ready,
        output eng_re_valid, eng_re_err, eng_re_is_finished, eng_re_winner, eng_re_tie,
        input  eng_re_ready,
        input  rsp_valid, rsp_player, rsp_err, rsp_finished, rsp_winner, rsp_tie,
        output rsp_ready
    );

endinterface

// File: rtl/connect4_sat_cnt.sv
// Saturating up-counter with synchronous clear.
module connect4_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/connect4_match_ctrl.sv
// Match controller: arbitrates player turns, forwards moves to the engine,
// returns results and keeps score across games.
module connect4_match_ctrl
    import connect4_pkg::*;
#(
    parameter int SCORE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    connect4_match_ctrl_if.master bus,
    output logic               turn,
    output logic               starter,
    output logic [MOVE_W-1:0]  move_cnt,
    output logic [SCORE_W-1:0] win0_cnt,
    output logic [SCORE_W-1:0] win1_cnt,
    output logic [SCORE_W-1:0] tie_cnt
);

    state_t           state;
    logic             p0_rdy;
    logic             p1_rdy;
    logic             op_vld;
    logic             re_rdy;
    logic             rsp_vld;
    logic             op_player;
    logic [COL_W-1:0] op_col;
    logic             res_err;
    logic             res_fin;
    logic             res_win;
    logic             res_tie;

    logic             rsp_fire;
    logic             move_ok;
    logic             game_done;
    logic             win0_inc;
    logic             win1_inc;
    logic             tie_inc;
    logic             turn_nxt;

    assign bus.p0_req_ready     = p0_rdy;
    assign bus.p1_req_ready     = p1_rdy;
    assign bus.eng_op_valid     = op_vld;
    assign bus.eng_op_player_id = op_player;
    assign bus.eng_op_col_id    = op_col;
    assign bus.eng_re_ready     = re_rdy;
    assign bus.rsp_valid        = rsp_vld;
    assign bus.rsp_player       = op_player;
    assign bus.rsp_err          = res_err;
    assign bus.rsp_finished     = res_fin;
    assign bus.rsp_winner       = res_win;
    assign bus.rsp_tie          = res_tie;

    // Score bookkeeping is qualified by the response handshake only.
    always_comb begin
        rsp_fire  = rsp_vld & bus.rsp_ready;
        move_ok   = rsp_fire & ~res_err;
        game_done = move_ok & res_fin;
        tie_inc   = game_done & res_tie;
        win1_inc  = game_done & ~res_tie & res_win;
        win0_inc  = game_done & ~res_tie & ~res_win;
        turn_nxt  = turn;
        if (game_done) begin
            turn_nxt = ~starter;
        end else if (move_ok) begin
            turn_nxt = ~turn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_REQ;
            p0_rdy    <= 1'b1;
            p1_rdy    <= 1'b0;
            op_vld    <= 1'b0;
            re_rdy    <= 1'b0;
            rsp_vld   <= 1'b0;
            op_player <= 1'b0;
            op_col    <= '0;
            res_err   <= 1'b0;
            res_fin   <= 1'b0;
            res_win   <= 1'b0;
            res_tie   <= 1'b0;
            turn      <= 1'b0;
            starter   <= 1'b0;
            move_cnt  <= '0;
        end else begin
            case (state)
                WAIT_REQ: begin
                    // ready is only ever high for the player on turn
                    if (p0_rdy && bus.p0_req_valid) begin
                        op_player <= 1'b0;
                        op_col    <= bus.p0_req_col;
                        p0_rdy    <= 1'b0;
                        op_vld    <= 1'b1;
                        state     <= ISSUE;
                    end else if (p1_rdy && bus.p1_req_valid) begin
                        op_player <= 1'b1;
                        op_col    <= bus.p1_req_col;
                        p1_rdy    <= 1'b0;
                        op_vld    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.eng_op_ready) begin
                        op_vld <= 1'b0;
                        re_rdy <= 1'b1;
                        state  <= WAIT_RE;
                    end
                end
                WAIT_RE: begin
                    if (bus.eng_re_valid) begin
                        res_err <= bus.eng_re_err;
                        res_fin <= bus.eng_re_is_finished;
                        res_win <= bus.eng_re_winner;
                        res_tie <= bus.eng_re_tie;
                        re_rdy  <= 1'b0;
                        rsp_vld <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_vld <= 1'b0;
                        turn    <= turn_nxt;
                        p0_rdy  <= ~turn_nxt;
                        p1_rdy  <= turn_nxt;
                        state   <= WAIT_REQ;
                        if (game_done) begin
                            move_cnt <= '0;
                            starter  <= ~starter;
                        end else if (move_ok && (move_cnt != MAX_MOVES)) begin
                            move_cnt <= move_cnt + MOVE_W'(1);
                        end
                    end
                end
                default: state <= WAIT_REQ;
            endcase
        end
    end

    connect4_sat_cnt #(.WIDTH(SCORE_W)) u_win0_cnt (
        .clk (clk),
        .clr (rst),
        .inc (win0_inc),
        .cnt (win0_cnt)
    );

    connect4_sat_cnt #(.WIDTH(SCORE_W)) u_win1_cnt (
        .clk (clk),
        .clr (rst),
        .inc (win1_inc),
        .cnt (win1_cnt)
    );

    connect4_sat_cnt #(.WIDTH(SCORE_W)) u_tie_cnt (
        .clk (clk),
        .clr (rst),
        .inc (tie_inc),
        .cnt (tie_cnt)
    );

endmodule

// File: tb/tb_connect4_match_ctrl.sv
// Directed bench for connect4_match_ctrl with a reference score model.
module tb_connect4_match_ctrl;
    import connect4_pkg::*;

    localparam int SCORE_W = 2;
    localparam int SAT     = 3;
    localparam int LIMIT   = 50;

    logic               clk;
    logic               rst;
    logic               turn;
    logic               starter;
    logic [MOVE_W-1:0]  move_cnt;
    logic [SCORE_W-1:0] win0_cnt;
    logic [SCORE_W-1:0] win1_cnt;
    logic [SCORE_W-1:0] tie_cnt;

    connect4_match_ctrl_if bus ();

    connect4_match_ctrl #(.SCORE_W(SCORE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .turn     (turn),
        .starter  (starter),
        .move_cnt (move_cnt),
        .win0_cnt (win0_cnt),
        .win1_cnt (win1_cnt),
        .tie_cnt  (tie_cnt)
    );

    typedef struct packed {
        logic       player;
        logic [2:0] col;
    } op_t;

    typedef struct packed {
        logic player;
        logic err;
        logic fin;
        logic win;
        logic tie;
    } rsp_t;

    op_t  opq[$];
    rsp_t rspq[$];

    int checks   = 0;
    int failures = 0;

    bit m_turn, m_starter;
    int m_move, m_w0, m_w1, m_tie;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_turn"},     32'(turn),     32'(m_turn));
        chk({tag, "_starter"},  32'(starter),  32'(m_starter));
        chk({tag, "_move_cnt"}, 32'(move_cnt), m_move);
        chk({tag, "_win0"},     32'(win0_cnt), m_w0);
        chk({tag, "_win1"},     32'(win1_cnt), m_w1);
        chk({tag, "_tie"},      32'(tie_cnt),  m_tie);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_p0_ready"},  32'(bus.p0_req_ready), 1);
        chk({tag, "_p1_ready"},  32'(bus.p1_req_ready), 0);
        chk({tag, "_op_valid"},  32'(bus.eng_op_valid), 0);
        chk({tag, "_re_ready"},  32'(bus.eng_re_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid),    0);
        chk({tag, "_rsp_data"},
            32'({bus.rsp_player, bus.rsp_err, bus.rsp_finished, bus.rsp_winner, bus.rsp_tie}), 0);
        m_turn = 0; m_starter = 0; m_move = 0; m_w0 = 0; m_w1 = 0; m_tie = 0;
        chk_status(tag);
    endtask

    task automatic do_move(input bit pl, input logic [2:0] col, input bit err, input bit fin,
                           input bit win, input bit tie, input int op_wait, input int rsp_wait);
        op_t  eo;
        rsp_t er;
        int   n;
        eo = '{player: pl, col: col};
        er = '{player: pl, err: err, fin: fin, win: win, tie: tie};
        opq.push_back(eo);
        rspq.push_back(er);

        if (pl) begin
            bus.p1_req_valid = 1'b1; bus.p1_req_col = col;
        end else begin
            bus.p0_req_valid = 1'b1; bus.p0_req_col = col;
        end
        n = 0;
        while (((pl ? bus.p1_req_ready : bus.p0_req_ready) !== 1'b1) && (n < LIMIT)) begin
            step(); n++;
        end
        if (n == LIMIT) chk("req_ready_timeout", 0, 1);
        step();
        if (pl) bus.p1_req_valid = 1'b0; else bus.p0_req_valid = 1'b0;

        chk("op_valid_next_cycle", 32'(bus.eng_op_valid), 1);
        eo = opq.pop_front();
        chk("op_player", 32'(bus.eng_op_player_id), 32'(eo.player));
        chk("op_col",    32'(bus.eng_op_col_id),    32'(eo.col));
        for (int i = 0; i < op_wait; i++) begin
            step();
            chk("op_hold_valid",  32'(bus.eng_op_valid),     1);
            chk("op_hold_player", 32'(bus.eng_op_player_id), 32'(eo.player));
            chk("op_hold_col",    32'(bus.eng_op_col_id),    32'(eo.col));
            chk("req_ready_busy", 32'({bus.p0_req_ready, bus.p1_req_ready}), 0);
        end
        bus.eng_op_ready = 1'b1;
        step();
        bus.eng_op_ready = 1'b0;
        chk("op_valid_drop", 32'(bus.eng_op_valid), 0);
        chk("re_ready_high", 32'(bus.eng_re_ready), 1);

        bus.eng_re_valid = 1'b1;
        bus.eng_re_err = err; bus.eng_re_is_finished = fin;
        bus.eng_re_winner = win; bus.eng_re_tie = tie;
        step();
        bus.eng_re_valid = 1'b0;
        bus.eng_re_err = 1'b0; bus.eng_re_is_finished = 1'b0;
        bus.eng_re_winner = 1'b0; bus.eng_re_tie = 1'b0;

        chk("rsp_valid_next_cycle", 32'(bus.rsp_valid), 1);
        chk("re_ready_drop", 32'(bus.eng_re_ready), 0);
        er = rspq.pop_front();
        for (int i = 0; i <= rsp_wait; i++) begin
            if (i > 0) step();
            chk("rsp_hold_valid", 32'(bus.rsp_valid), 1);
            chk("rsp_fields",
                32'({bus.rsp_player, bus.rsp_err, bus.rsp_finished, bus.rsp_winner, bus.rsp_tie}),
                32'(er));
            chk_status("pre_fire");
        end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid), 0);

        if (!err) begin
            if (fin) begin
                if (tie) m_tie = (m_tie < SAT) ? m_tie + 1 : m_tie;
                else if (win) m_w1 = (m_w1 < SAT) ? m_w1 + 1 : m_w1;
                else m_w0 = (m_w0 < SAT) ? m_w0 + 1 : m_w0;
                m_move = 0;
                m_starter = !m_starter;
                m_turn = m_starter;
            end else begin
                m_turn = !m_turn;
                if (m_move < 42) m_move++;
            end
        end
        chk_status("post_fire");
    endtask

    initial begin
        rst = 1'b1;
        bus.p0_req_valid = 1'b0; bus.p0_req_col = '0;
        bus.p1_req_valid = 1'b0; bus.p1_req_col = '0;
        bus.eng_op_ready = 1'b0;
        bus.eng_re_valid = 1'b0; bus.eng_re_err = 1'b0; bus.eng_re_is_finished = 1'b0;
        bus.eng_re_winner = 1'b0; bus.eng_re_tie = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (3) step();
        chk_reset("reset");
        rst = 1'b0;
        step();

        // first move by player 0, column 3
        do_move(1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // both players request while it is player 1's turn
        bus.p0_req_valid = 1'b1; bus.p0_req_col = 3'd2;
        chk("p0_ready_off_turn", 32'(bus.p0_req_ready), 0);
        do_move(1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
        do_move(1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // engine error: same player retries
        do_move(1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        do_move(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // player 0 wins on move 7
        do_move(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_move(1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_move(1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);

        // four player-1 wins saturate the 2-bit counter
        do_move(1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        do_move(1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_move(1'b1, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        do_move(1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        do_move(1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        do_move(1'b1, 3'd6, 1'b0, 1'b1, 1'b1, 1'b0, 5, 5);

        // full board ending in a tie on move 42
        for (int i = 1; i <= 41; i++) begin
            do_move(m_turn, 3'(i % 7), 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        end
        chk("move_cnt_41", 32'(move_cnt), 41);
        do_move(m_turn, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 5, 5);

        // reset while waiting for the engine result
        bus.p0_req_valid = 1'b1; bus.p0_req_col = 3'd5;
        step();
        bus.p0_req_valid = 1'b0;
        bus.eng_op_ready = 1'b1;
        step();
        bus.eng_op_ready = 1'b0;
        chk("mid_re_ready", 32'(bus.eng_re_ready), 1);
        rst = 1'b1;
        step();
        chk_reset("mid_reset");
        rst = 1'b0;
        step();
        do_move(1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/connect4_match_ctrl.md
CONNECT4_MATCH_CTRL -- requirements
Module: connect4_match_ctrl

Interface
REQ-001 SHALL have parameter SCORE_W, default 8: width of the saturating win/tie counters.
REQ-002 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-003 SHALL have ports: p0_req_valid in 1, p0_req_ready out 1, p0_req_col in 3  player-0 move request.
REQ-004 SHALL have ports: p1_req_valid in 1, p1_req_ready out 1, p1_req_col in 3  player-1 move request.
REQ-005 SHALL have ports: eng_op_valid out 1, eng_op_ready in 1, eng_op_player_id out 1, eng_op_col_id out 3  move issue to the connect4 engine.
REQ-006 SHALL have ports: eng_re_valid in 1, eng_re_ready out 1, eng_re_err/eng_re_is_finished/eng_re_winner/eng_re_tie in 1 each  engine result.
REQ-007 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_player out 1, rsp_err out 1, rsp_finished out 1, rsp_winner out 1, rsp_tie out 1  result returned to players.
REQ-008 SHALL have ports: turn out 1, starter out 1, move_cnt out 6, win0_cnt/win1_cnt/tie_cnt out SCORE_W  match status.

Function
REQ-009 SHALL implement FSM states WAIT_REQ, ISSUE, WAIT_RE, RESP; all outputs registered or decoded from registered state only.
REQ-010 SHALL assert pX_req_ready only in WAIT_REQ with turn==X; off-turn player's request is never accepted (held, not dropped).
REQ-011 On pX request fire SHALL capture player X and column, go to ISSUE; eng_op_valid high the next cycle.
REQ-012 In ISSUE SHALL hold eng_op_valid, eng_op_player_id, eng_op_col_id stable until eng_op_ready; on fire deassert valid and go to WAIT_RE.
REQ-013 In WAIT_RE SHALL hold eng_re_ready high; on eng_re fire capture all four result bits, go to RESP; rsp_valid high the next cycle.
REQ-014 In RESP SHALL hold rsp_* stable with rsp_player = captured player until rsp_ready; on fire deassert rsp_valid, return to WAIT_REQ.
REQ-015 All bookkeeping SHALL update on the rsp fire cycle, not earlier.
REQ-016 Error result (rsp_err=1): turn, move_cnt, counters unchanged; same player moves again.
REQ-017 Non-error, non-finished: turn toggles; move_cnt increments.
REQ-018 Finished with win: winner's win counter increments; finished with tie: tie_cnt increments.
REQ-019 On any finished result: move_cnt clears to 0; starter toggles; turn set to new starter value.
REQ-020 Win/tie counters SHALL saturate at 2^SCORE_W-1; saturated counter stays there, others still count.
REQ-021 move_cnt SHALL never exceed 42; finished result at move 42 clears it per REQ-019.
REQ-022 Request valid while not in WAIT_REQ SHALL be ignored (ready low); both players valid simultaneously: only turn player's accepted.
REQ-023 Minimum loop latency: request fire to rsp_valid high = 2 cycles + engine op wait + engine result latency.

Reset
REQ-024 On rst: state WAIT_REQ, turn=0, starter=0, move_cnt=0, all counters 0, eng_op_valid=0, eng_re_ready=0, rsp_valid=0, rsp_* data 0, p0_req_ready=1, p1_req_ready=0.
REQ-025 rst mid-transaction SHALL abandon it with no counter update; integration SHALL reset engine in the same cycle.

Structure
REQ-026 Shared package connect4_pkg SHALL hold the FSM state enum, column width (3), move_cnt width (6), and MAX_MOVES=42.
REQ-027 Saturating counter SHALL be one sub-module connect4_sat_cnt (params width; inputs inc, clr), instantiated three times.

Verification
REQ-028 Reset, p0 col 3, engine ok not finished -> eng_op player 0 col 3; rsp_player 0, err 0; turn=1, move_cnt=1.
REQ-029 Turn=1, p0 and p1 valid together -> only p1 accepted; p0_req_ready stays 0; p0 accepted after rsp fire.
REQ-030 Engine returns err for p1 col 6 -> rsp_err 1; turn stays 1, move_cnt unchanged; p1 re-requested.
REQ-031 Player 0 wins on move 7 -> rsp_finished 1, rsp_winner 0; win0_cnt=1, move_cnt=0, starter=1, turn=1.
REQ-032 Engine tie at move 42; SCORE_W=2 with 4 p1 wins -> tie_cnt=1; win1_cnt saturates at 3; eng_op_ready/rsp_ready held low 5 cycles -> outputs stable.
